// File: rtl/rv_ecc_pkg.sv
// Shared types and constants for the ECC scrub path.
package rv_ecc_pkg;

    localparam int SCRUB_AW = 16;
    localparam int DATA_W   = 32;
    localparam int ECC_W    = 7;

    typedef struct packed {
        logic [SCRUB_AW-1:0] addr;
        logic [DATA_W-1:0]   data;
    } scrub_entry_t;

endpackage

// File: rtl/rv_ecc_scrub_fifo.sv
// Circular scrub queue with wrap-bit pointers and a last-written-address tap.
module rv_ecc_scrub_fifo
    import rv_ecc_pkg::*;
#(
    parameter int AW    = 16,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [AW-1:0]     o_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_wr_drop,
    output logic [AW-1:0]     o_last_addr
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]       r_wr_ptr;
    logic [PW:0]       r_rd_ptr;
    logic [AW-1:0]     r_addr_mem [DEPTH];
    logic [DATA_W-1:0] r_data_mem [DEPTH];
    logic [AW-1:0]     r_last_addr;
    logic              w_rd_go;
    logic              w_wr_go;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]) && (r_wr_ptr[PW] != r_rd_ptr[PW]);
    assign w_rd_go   = i_rd_en & ~o_empty;
    // A full queue still takes a write when the head leaves in the same cycle.
    assign w_wr_go   = i_wr_en & (~o_full | w_rd_go);
    assign o_wr_drop = i_wr_en & ~w_wr_go;

    assign o_rd_addr   = r_addr_mem[r_rd_ptr[PW-1:0]];
    assign o_rd_data   = r_data_mem[r_rd_ptr[PW-1:0]];
    assign o_last_addr = r_last_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_last_addr <= '0;
        end else begin
            if (w_wr_go) begin
                r_wr_ptr    <= r_wr_ptr + 1'b1;
                r_last_addr <= i_wr_addr;
            end
            if (w_rd_go) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // NOTE: storage is not reset; empty pointers guarantee no stale entry is ever presented.
    always_ff @(posedge clk) begin
        if (w_wr_go) begin
            r_addr_mem[r_wr_ptr[PW-1:0]] <= i_wr_addr;
            r_data_mem[r_wr_ptr[PW-1:0]] <= i_wr_data;
        end
    end

endmodule

// File: rtl/rvecc_encode.sv
// SECDED (39,32) encoder: six Hamming check bits plus overall parity in bit 6.
module rvecc_encode
    import rv_ecc_pkg::*;
(
    input  logic [DATA_W-1:0] i_din,
    output logic [ECC_W-1:0]  o_ecc
);

    logic [5:0] w_syn;
    logic [4:0] w_didx;

    // Data bits occupy codeword positions 1..38 that are not powers of two.
    always_comb begin
        w_syn  = '0;
        w_didx = '0;
        for (int p = 1; p < 39; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (i_din[w_didx]) begin
                    w_syn = w_syn ^ p[5:0];
                end
                w_didx = w_didx + 5'd1;
            end
        end
    end

    assign o_ecc = {^{i_din, w_syn}, w_syn};

endmodule

// File: rtl/rv_ecc_scrub_ctl.sv
// ECC scrub controller: queues single-error write-backs, counts errors, logs first double error.
// Optional error counters and double-error log are built when RV_ECC_ERR_CNT_EN is defined.
module rv_ecc_scrub_ctl
    import rv_ecc_pkg::*;
#(
    parameter int AW    = 16,
    parameter int DEPTH = 4,
    parameter int CW    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rd_valid,
    input  logic [AW-1:0]     i_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    input  logic              i_single_err,
    input  logic              i_double_err,
    input  logic              i_scrub_en,
    input  logic              i_clr_cnt,
    output logic              o_wb_valid,
    input  logic              i_wb_ready,
    output logic [AW-1:0]     o_wb_addr,
    output logic [DATA_W-1:0] o_wb_data,
    output logic [ECC_W-1:0]  o_wb_ecc,
    output logic [CW-1:0]     o_sb_err_cnt,
    output logic [CW-1:0]     o_db_err_cnt,
    output logic              o_db_err_valid,
    output logic [AW-1:0]     o_db_err_addr,
    output logic              o_scrub_ovf,
    output logic              o_busy
);

    logic              r_s1_valid;
    logic [AW-1:0]     r_s1_addr;
    logic [DATA_W-1:0] r_s1_data;
    logic              r_s1_single;
    logic              r_s1_double;
    logic              r_scrub_ovf;
    logic              w_empty;
    logic              w_full;
    logic              w_wr_drop;
    logic [AW-1:0]     w_last_addr;
    logic              w_sb_hit;
    logic              w_dup;
    logic              w_enq;
    logic              w_deq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= i_rd_valid;
        end
    end

    always_ff @(posedge clk) begin
        r_s1_addr   <= i_rd_addr;
        r_s1_data   <= i_rd_data;
        r_s1_single <= i_single_err;
        r_s1_double <= i_double_err;
    end

    assign w_sb_hit   = r_s1_valid & r_s1_single;
    assign w_dup      = ~w_empty & (r_s1_addr == w_last_addr);
    assign w_enq      = w_sb_hit & ~r_s1_double & i_scrub_en & ~w_dup;
    assign o_wb_valid = ~w_empty;
    assign w_deq      = o_wb_valid & i_wb_ready;
    assign o_busy     = r_s1_valid | ~w_empty;

    rv_ecc_scrub_fifo #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_wr_en     (w_enq),
        .i_wr_addr   (r_s1_addr),
        .i_wr_data   (r_s1_data),
        .i_rd_en     (w_deq),
        .o_rd_addr   (o_wb_addr),
        .o_rd_data   (o_wb_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_wr_drop   (w_wr_drop),
        .o_last_addr (w_last_addr)
    );

    rvecc_encode u_enc (
        .i_din (o_wb_data),
        .o_ecc (o_wb_ecc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scrub_ovf <= 1'b0;
        end else if (i_clr_cnt) begin
            r_scrub_ovf <= 1'b0;
        end else if (w_wr_drop && w_full) begin
            r_scrub_ovf <= 1'b1;
        end
    end

    assign o_scrub_ovf = r_scrub_ovf;

`ifdef RV_ECC_ERR_CNT_EN
    logic          w_db_hit;
    logic [CW-1:0] r_sb_cnt;
    logic [CW-1:0] r_db_cnt;
    logic          r_db_valid;
    logic [AW-1:0] r_db_addr;

    assign w_db_hit = r_s1_valid & r_s1_double;

    // Clear has priority over any same-cycle increment or capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sb_cnt   <= '0;
            r_db_cnt   <= '0;
            r_db_valid <= 1'b0;
            r_db_addr  <= '0;
        end else if (i_clr_cnt) begin
            r_sb_cnt   <= '0;
            r_db_cnt   <= '0;
            r_db_valid <= 1'b0;
            r_db_addr  <= '0;
        end else begin
            if (w_sb_hit && (r_sb_cnt != '1)) begin
                r_sb_cnt <= r_sb_cnt + 1'b1;
            end
            if (w_db_hit && (r_db_cnt != '1)) begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
            if (w_db_hit && !r_db_valid) begin
                r_db_valid <= 1'b1;
                r_db_addr  <= r_s1_addr;
            end
        end
    end

    assign o_sb_err_cnt   = r_sb_cnt;
    assign o_db_err_cnt   = r_db_cnt;
    assign o_db_err_valid = r_db_valid;
    assign o_db_err_addr  = r_db_addr;
`else
    assign o_sb_err_cnt   = '0;
    assign o_db_err_cnt   = '0;
    assign o_db_err_valid = 1'b0;
    assign o_db_err_addr  = '0;
`endif

endmodule

// File: tb/tb_rv_ecc_scrub_ctl.sv
// Scoreboard bench for rv_ecc_scrub_ctl; counter checks follow RV_ECC_ERR_CNT_EN.
module tb_rv_ecc_scrub_ctl;
    import rv_ecc_pkg::*;

    localparam int AW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 16;
`ifdef RV_ECC_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd_valid = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [31:0]   rd_data = '0;
    logic          single_err = 1'b0;
    logic          double_err = 1'b0;
    logic          scrub_en = 1'b0;
    logic          clr_cnt = 1'b0;
    logic          wb_valid;
    logic          wb_ready = 1'b0;
    logic [AW-1:0] wb_addr;
    logic [31:0]   wb_data;
    logic [6:0]    wb_ecc;
    logic [CW-1:0] sb_err_cnt;
    logic [CW-1:0] db_err_cnt;
    logic          db_err_valid;
    logic [AW-1:0] db_err_addr;
    logic          scrub_ovf;
    logic          busy;

    int           n_checks = 0;
    int           n_fail   = 0;
    scrub_entry_t sb_q[$];
    scrub_entry_t m_e;
    int           exp_sb = 0;
    int           exp_db = 0;
    bit           exp_db_valid = 1'b0;
    logic [15:0]  exp_db_addr = '0;
    bit           exp_ovf = 1'b0;

    rv_ecc_scrub_ctl #(.AW(AW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_rd_valid     (rd_valid),
        .i_rd_addr      (rd_addr),
        .i_rd_data      (rd_data),
        .i_single_err   (single_err),
        .i_double_err   (double_err),
        .i_scrub_en     (scrub_en),
        .i_clr_cnt      (clr_cnt),
        .o_wb_valid     (wb_valid),
        .i_wb_ready     (wb_ready),
        .o_wb_addr      (wb_addr),
        .o_wb_data      (wb_data),
        .o_wb_ecc       (wb_ecc),
        .o_sb_err_cnt   (sb_err_cnt),
        .o_db_err_cnt   (db_err_cnt),
        .o_db_err_valid (db_err_valid),
        .o_db_err_addr  (db_err_addr),
        .o_scrub_ovf    (scrub_ovf),
        .o_busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] ecc_model(input logic [31:0] d);
        logic [6:0] e;
        e[0] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[11]^d[13]^d[15]^d[17]^d[19]^d[21]^d[23]^d[25]^d[26]^d[28]^d[30];
        e[1] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[10]^d[12]^d[13]^d[16]^d[17]^d[20]^d[21]^d[24]^d[25]^d[27]^d[28]^d[31];
        e[2] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[10]^d[14]^d[15]^d[16]^d[17]^d[22]^d[23]^d[24]^d[25]^d[29]^d[30]^d[31];
        e[3] = (^d[10:4]) ^ (^d[25:18]);
        e[4] = ^d[25:11];
        e[5] = ^d[31:26];
        e[6] = (^d) ^ (^e[5:0]);
        return e;
    endfunction

    function automatic logic [63:0] cnt_exp(input logic [63:0] v);
        return CNT_EN ? v : 64'd0;
    endfunction

    // Handshake monitor: every accepted write-back must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && wb_valid && wb_ready) begin
            if (sb_q.size() == 0) begin
                check("wb_unexpected", 1, 0);
            end else begin
                m_e = sb_q.pop_front();
                check("wb_addr", wb_addr, m_e.addr);
                check("wb_data", wb_data, m_e.data);
                check("wb_ecc", wb_ecc, ecc_model(m_e.data));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_beat(input logic [15:0] a, input logic [31:0] d, input bit s, input bit dd);
        rd_valid   = 1'b1;
        rd_addr    = a;
        rd_data    = d;
        single_err = s;
        double_err = dd;
        @(posedge clk);
        #1;
        rd_valid   = 1'b0;
        single_err = 1'b0;
        double_err = 1'b0;
        if (s) exp_sb = (exp_sb == 65535) ? 65535 : exp_sb + 1;
        if (dd) begin
            exp_db = (exp_db == 65535) ? 65535 : exp_db + 1;
            if (!exp_db_valid) begin
                exp_db_valid = 1'b1;
                exp_db_addr  = a;
            end
        end
    endtask

    task automatic clear_counts();
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt      = 1'b0;
        exp_sb       = 0;
        exp_db       = 0;
        exp_db_valid = 1'b0;
        exp_db_addr  = '0;
        exp_ovf      = 1'b0;
    endtask

    task automatic push_exp(input logic [15:0] a, input logic [31:0] d);
        scrub_entry_t e;
        e.addr = a;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain(input string tag);
        int cyc = 0;
        while ((sb_q.size() != 0 || busy) && cyc < 200) begin
            cycles(1);
            cyc++;
        end
        check({tag, "_drained"}, (sb_q.size() != 0) || busy, 0);
        check({tag, "_wbv_idle"}, wb_valid, 0);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_sb_cnt"}, sb_err_cnt, cnt_exp(exp_sb));
        check({tag, "_db_cnt"}, db_err_cnt, cnt_exp(exp_db));
        check({tag, "_db_valid"}, db_err_valid, cnt_exp(exp_db_valid));
        check({tag, "_db_addr"}, db_err_addr, cnt_exp(exp_db_addr));
        check({tag, "_ovf"}, scrub_ovf, exp_ovf);
    endtask

    initial begin
        #50000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cycles(3);
        rst = 1'b0;
        cycles(2);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_busy", busy, 0);
        check_counts("rst");

        // Single error, ready high: two-cycle latency to wb_valid.
        scrub_en = 1'b1;
        wb_ready = 1'b1;
        push_exp(16'h0040, 32'hDEADBEEF);
        drive_beat(16'h0040, 32'hDEADBEEF, 1'b1, 1'b0);
        check("t1_wbv_n1", wb_valid, 0);
        cycles(1);
        check("t1_wbv_n2", wb_valid, 1);
        check("t1_addr", wb_addr, 16'h0040);
        check("t1_ecc", wb_ecc, ecc_model(32'hDEADBEEF));
        check_counts("t1");
        wait_drain("t1");

        // Back-pressure with six distinct errors: four queued, two dropped.
        wb_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < DEPTH) push_exp(16'h0100 + 16'(i), 32'h1000_0000 + 32'(i * 7));
            drive_beat(16'h0100 + 16'(i), 32'h1000_0000 + 32'(i * 7), 1'b1, 1'b0);
        end
        exp_ovf = 1'b1;
        cycles(2);
        for (int i = 0; i < 3; i++) begin
            check("t2_hold_valid", wb_valid, 1);
            check("t2_hold_addr", wb_addr, 16'h0100);
            check("t2_hold_data", wb_data, 32'h1000_0000);
            cycles(1);
        end
        check_counts("t2");
        wb_ready = 1'b1;
        wait_drain("t2");

        // Same address on three consecutive beats collapses to one entry.
        clear_counts();
        wb_ready = 1'b0;
        push_exp(16'h0010, 32'hA5A5_0010);
        for (int i = 0; i < 3; i++) drive_beat(16'h0010, 32'hA5A5_0010, 1'b1, 1'b0);
        cycles(2);
        check_counts("t3");
        wb_ready = 1'b1;
        wait_drain("t3");

        // Double errors: logged once, counted, never queued.
        drive_beat(16'h0020, 32'h0000_0020, 1'b0, 1'b1);
        drive_beat(16'h0030, 32'h0000_0030, 1'b0, 1'b1);
        cycles(2);
        check_counts("t4a");
        drive_beat(16'h0050, 32'h0000_0050, 1'b1, 1'b1);
        cycles(2);
        check_counts("t4b");
        wait_drain("t4");

        // Saturation, then clear colliding with an error.
        scrub_en = 1'b0;
        clear_counts();
        for (int i = 0; i < 65535; i++) drive_beat(16'h0060, 32'h0, 1'b1, 1'b1);
        cycles(2);
        check("t5_sb_full", sb_err_cnt, cnt_exp(16'hFFFF));
        check("t5_db_full", db_err_cnt, cnt_exp(16'hFFFF));
        drive_beat(16'h0061, 32'h0, 1'b1, 1'b1);
        cycles(2);
        check_counts("t5_sat");
        drive_beat(16'h0062, 32'h0, 1'b1, 1'b1);
        clear_counts();
        cycles(1);
        check_counts("t5_clr");

        // Full queue with same-cycle dequeue and enqueue, then reset mid-flight.
        scrub_en = 1'b1;
        wb_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            push_exp(16'h0200 + 16'(i), 32'hC0DE_0000 + 32'(i));
            drive_beat(16'h0200 + 16'(i), 32'hC0DE_0000 + 32'(i), 1'b1, 1'b0);
        end
        cycles(2);
        push_exp(16'h0204, 32'hC0DE_0004);
        drive_beat(16'h0204, 32'hC0DE_0004, 1'b1, 1'b0);
        wb_ready = 1'b1;
        cycles(1);
        wb_ready = 1'b0;
        check_counts("t6");
        check("t6_valid", wb_valid, 1);
        check("t6_head", wb_addr, 16'h0201);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_wbv", wb_valid, 0);
        check("t6_rst_busy", busy, 0);
        sb_q.delete();
        exp_sb = 0;
        exp_db = 0;
        exp_db_valid = 1'b0;
        exp_db_addr = '0;
        exp_ovf = 1'b0;
        cycles(2);
        rst = 1'b0;
        wb_ready = 1'b1;
        cycles(3);
        check("t6_post_wbv", wb_valid, 0);
        check_counts("t6_post");
        push_exp(16'h0300, 32'h1234_5678);
        drive_beat(16'h0300, 32'h1234_5678, 1'b1, 1'b0);
        wait_drain("t6_post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
